// File: rtl/fetch_thr_pc_gen_if.sv
// rtl/fetch_thr_pc_gen_if.sv - F-stage thread select / PC generator signal bundle
interface fetch_thr_pc_gen_if;
  logic [3:0]  thr_en;
  logic        stall_f;
  logic        redirect_vld;
  logic [3:0]  redirect_thr;
  logic [47:0] redirect_pc;
  logic        inst_vld_f;
  logic [3:0]  thr_f;
  logic [47:0] pc_f;
  logic [47:0] t0pc_f;
  logic [47:0] t1pc_f;
  logic [47:0] t2pc_f;
  logic [47:0] t3pc_f;

  // Driver side: the control logic feeding enables, stalls and redirects.
  modport master (
    output thr_en, stall_f, redirect_vld, redirect_thr, redirect_pc,
    input  inst_vld_f, thr_f, pc_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f
  );

  // Scheduler side.
  modport slave (
    input  thr_en, stall_f, redirect_vld, redirect_thr, redirect_pc,
    output inst_vld_f, thr_f, pc_f, t0pc_f, t1pc_f, t2pc_f, t3pc_f
  );
endinterface

// File: rtl/fetch_thr_pc_gen.sv
// rtl/fetch_thr_pc_gen.sv - 4-thread round-robin fetch scheduler and per-thread PC generator
module fetch_thr_pc_gen #(
  parameter logic [47:0] RESET_PC = 48'hFFFF_F000_0020
) (
  input logic              clk,
  input logic              reset,
  fetch_thr_pc_gen_if.slave fif
);

  logic [47:0] tpc     [4];
  logic [47:0] tpc_nxt [4];
  logic [1:0]  rr_last;
  logic [3:0]  thr_q;
  logic [47:0] pc_q;
  logic        vld_q;

  logic        acc;
  logic        sel_ok;
  logic        grant_vld;
  logic [1:0]  grant;
  logic [1:0]  held_idx;
  logic        held_redirect;

  assign acc    = vld_q & ~fif.stall_f;
  assign sel_ok = ~vld_q | ~fif.stall_f;

  // Per-thread next PC: redirect beats sequential advance, which beats hold.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      tpc_nxt[n] = tpc[n];
      if (fif.redirect_vld && fif.redirect_thr[n]) begin
        tpc_nxt[n] = {fif.redirect_pc[47:2], 2'b00};
      end else if (acc && thr_q[n]) begin
        tpc_nxt[n] = tpc[n] + 48'd4;
      end
    end
  end

  // Round-robin search starting just after the last granted thread.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant     = rr_last;
    idx       = rr_last;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_last + 2'(i);
      if (!grant_vld && fif.thr_en[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Index of the thread currently held in F, used to track redirects while stalled.
  always_comb begin
    held_idx = 2'd0;
    for (int n = 0; n < 4; n++) begin
      if (thr_q[n]) held_idx = 2'(n);
    end
    held_redirect = fif.redirect_vld && |(fif.redirect_thr & thr_q);
  end

  // Thread PC registers and F-stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) tpc[n] <= RESET_PC;
      pc_q    <= RESET_PC;
      thr_q   <= 4'b0000;
      vld_q   <= 1'b0;
      rr_last <= 2'd3;
    end else begin
      for (int n = 0; n < 4; n++) tpc[n] <= tpc_nxt[n];
      if (sel_ok) begin
        if (grant_vld) begin
          thr_q   <= 4'b0001 << grant;
          vld_q   <= 1'b1;
          rr_last <= grant;
          pc_q    <= tpc_nxt[grant];
        end else begin
          thr_q <= 4'b0000;
          vld_q <= 1'b0;
        end
      end else if (held_redirect) begin
        pc_q <= tpc_nxt[held_idx];
      end
    end
  end

  assign fif.inst_vld_f = vld_q;
  assign fif.thr_f      = thr_q;
  assign fif.pc_f       = pc_q;
  assign fif.t0pc_f     = tpc[0];
  assign fif.t1pc_f     = tpc[1];
  assign fif.t2pc_f     = tpc[2];
  assign fif.t3pc_f     = tpc[3];

endmodule

// File: tb/tb_fetch_thr_pc_gen.sv
// tb/tb_fetch_thr_pc_gen.sv - directed and randomized check of fetch_thr_pc_gen against a reference model
module tb_fetch_thr_pc_gen;

  localparam logic [47:0] RST_PC = 48'hFFFF_F000_0020;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  fetch_thr_pc_gen_if fif ();

  fetch_thr_pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (rst),
    .fif   (fif)
  );

  always #5 clk = ~clk;

  // Reference model: thread PCs, last grant, and what sits in F (thread index or -1).
  logic [47:0] m_tpc [4];
  logic [47:0] m_pc;
  int          m_rr;
  int          m_thr;
  bit          m_vld;

  task automatic model_edge(input logic r, input logic [3:0] en, input logic st,
                            input logic rv, input logic [3:0] rt, input logic [47:0] rp);
    logic [47:0] nt [4];
    bit accept;
    bit can_sel;
    int found;
    int c;
    if (r) begin
      for (int n = 0; n < 4; n++) m_tpc[n] = RST_PC;
      m_pc  = RST_PC;
      m_rr  = 3;
      m_thr = -1;
      m_vld = 0;
      return;
    end
    accept  = m_vld && !st;
    can_sel = !m_vld || !st;
    for (int n = 0; n < 4; n++) begin
      nt[n] = m_tpc[n];
      if (rv && rt[n]) nt[n] = {rp[47:2], 2'b00};
      else if (accept && m_thr == n) nt[n] = m_tpc[n] + 48'd4;
    end
    if (can_sel) begin
      found = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_rr + k) % 4;
        if (found < 0 && en[c]) found = c;
      end
      if (found >= 0) begin
        m_thr = found;
        m_vld = 1;
        m_rr  = found;
        m_pc  = nt[found];
      end else begin
        m_thr = -1;
        m_vld = 0;
      end
    end else if (rv && rt[m_thr]) begin
      m_pc = nt[m_thr];
    end
    for (int n = 0; n < 4; n++) m_tpc[n] = nt[n];
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] et;
    et = m_vld ? (4'b0001 << m_thr) : 4'b0000;
    chk("vld",   {47'd0, fif.inst_vld_f}, {47'd0, m_vld});
    chk("thr",   {44'd0, fif.thr_f}, {44'd0, et});
    chk("pc_f",  fif.pc_f, m_pc);
    chk("t0pc",  fif.t0pc_f, m_tpc[0]);
    chk("t1pc",  fif.t1pc_f, m_tpc[1]);
    chk("t2pc",  fif.t2pc_f, m_tpc[2]);
    chk("t3pc",  fif.t3pc_f, m_tpc[3]);
  endtask

  task automatic cyc(input logic r, input logic [3:0] en, input logic st,
                     input logic rv, input logic [3:0] rt, input logic [47:0] rp);
    rst              = r;
    fif.thr_en       = en;
    fif.stall_f      = st;
    fif.redirect_vld = rv;
    fif.redirect_thr = rt;
    fif.redirect_pc  = rp;
    model_edge(r, en, st, rv, rt, rp);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0]  exp_thr [5];
    logic [47:0] exp_pc  [5];
    logic [47:0] saved;
    logic [3:0]  ren;
    logic [3:0]  rthr;
    logic [47:0] rpc;
    bit          hit;

    exp_thr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    exp_pc  = '{48'hFFFF_F000_0020, 48'hFFFF_F000_0020, 48'hFFFF_F000_0020,
                48'hFFFF_F000_0020, 48'hFFFF_F000_0024};

    // Reset, held for two cycles.
    cyc(1, 4'hF, 0, 0, 4'h0, 48'd0);
    cyc(1, 4'hF, 0, 0, 4'h0, 48'd0);
    chk("rst_vld", {47'd0, fif.inst_vld_f}, 48'd0);
    chk("rst_pc", fif.pc_f, RST_PC);

    // All threads enabled: 0,1,2,3,0 with thread 0 advancing once.
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'hF, 0, 0, 4'h0, 48'd0);
      chk("rr_thr", {44'd0, fif.thr_f}, {44'd0, exp_thr[k]});
      chk("rr_pc", fif.pc_f, exp_pc[k]);
      if (k >= 1) chk("rr_t0pc", fif.t0pc_f, 48'hFFFF_F000_0024);
    end

    // Single thread 2 with a three-cycle stall.
    cyc(0, 4'b0100, 0, 0, 4'h0, 48'd0);
    saved = fif.pc_f;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 4'b0100, 1, 0, 4'h0, 48'd0);
      chk("stall_thr", {44'd0, fif.thr_f}, 48'h4);
      chk("stall_pc", fif.pc_f, saved);
    end
    cyc(0, 4'b0100, 0, 0, 4'h0, 48'd0);
    chk("unstall_pc1", fif.pc_f, saved + 48'd4);
    cyc(0, 4'b0100, 0, 0, 4'h0, 48'd0);
    chk("unstall_pc2", fif.pc_f, saved + 48'd8);

    // Redirect thread 1 while it is in F and accepted.
    hit = 0;
    for (int k = 0; k < 6 && !hit; k++) begin
      cyc(0, 4'hF, 0, 0, 4'h0, 48'd0);
      hit = (m_thr == 1);
    end
    chk("wait_t1_in_f", {47'd0, hit}, 48'd1);
    cyc(0, 4'hF, 0, 1, 4'b0010, 48'h0000_0000_1003);
    chk("redir_t1pc", fif.t1pc_f, 48'h0000_0000_1000);
    hit = 0;
    for (int k = 0; k < 6 && !hit; k++) begin
      cyc(0, 4'hF, 0, 0, 4'h0, 48'd0);
      hit = (m_thr == 1);
    end
    chk("wait_t1_regrant", {47'd0, hit}, 48'd1);
    chk("redir_t1_pc_f", fif.pc_f, 48'h0000_0000_1000);

    // Redirect the thread held under stall.
    cyc(0, 4'b0001, 0, 0, 4'h0, 48'd0);
    cyc(0, 4'b0001, 0, 0, 4'h0, 48'd0);
    cyc(0, 4'b0001, 1, 0, 4'h0, 48'd0);
    cyc(0, 4'b0001, 1, 1, 4'b0001, 48'h0000_0000_2002);
    chk("stallredir_pc", fif.pc_f, 48'h0000_0000_2000);
    chk("stallredir_t0", fif.t0pc_f, 48'h0000_0000_2000);
    chk("stallredir_vld", {47'd0, fif.inst_vld_f}, 48'd1);
    cyc(0, 4'b0001, 0, 0, 4'h0, 48'd0);

    // PC wrap on thread 3.
    cyc(0, 4'b1000, 0, 0, 4'h0, 48'd0);
    cyc(0, 4'b1000, 0, 0, 4'h0, 48'd0);
    cyc(0, 4'b1000, 0, 1, 4'b1000, 48'hFFFF_FFFF_FFFC);
    chk("wrap_pc0", fif.pc_f, 48'hFFFF_FFFF_FFFC);
    cyc(0, 4'b1000, 0, 0, 4'h0, 48'd0);
    chk("wrap_pc1", fif.pc_f, 48'h0000_0000_0000);
    cyc(0, 4'b1000, 0, 0, 4'h0, 48'd0);
    chk("wrap_pc2", fif.pc_f, 48'h0000_0000_0004);

    // No enabled thread, then thread 2, then reset mid-stream.
    cyc(0, 4'b0000, 0, 0, 4'h0, 48'd0);
    chk("idle_vld", {47'd0, fif.inst_vld_f}, 48'd0);
    chk("idle_thr", {44'd0, fif.thr_f}, 48'd0);
    cyc(0, 4'b0100, 0, 0, 4'h0, 48'd0);
    chk("en2_thr", {44'd0, fif.thr_f}, 48'h4);
    cyc(1, 4'b0100, 1, 1, 4'b0100, 48'h0000_0000_3000);
    chk("midrst_vld", {47'd0, fif.inst_vld_f}, 48'd0);
    chk("midrst_thr", {44'd0, fif.thr_f}, 48'd0);
    chk("midrst_pc", fif.pc_f, RST_PC);
    chk("midrst_t2", fif.t2pc_f, RST_PC);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      ren  = 4'($urandom_range(0, 15));
      rthr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                         : (4'b0001 << $urandom_range(0, 3));
      rpc  = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) rpc = 48'hFFFF_FFFF_FFF0 | 48'($urandom_range(0, 15));
      cyc(($urandom_range(0, 49) == 0), ren, ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 4) == 0), rthr, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_thr_pc_gen.md
# fetch_thr_pc_gen

Fetch-stage thread scheduler and PC generator for the 4-thread SPARC core IFU. Each cycle it picks one enabled thread round-robin and presents that thread's fetch PC in the F-stage, with the one-hot thread select. It also keeps the four per-thread next-fetch PC registers, applying sequential +4 advance and branch/trap redirects. It drives the F-stage `thr_f`/`pc_f`/`tNpc_f` signals. The invariant `pc_f == tNpc_f` for the selected thread N holds on every cycle with `inst_vld_f` high.

## Interface
- RESET_PC, 48'hFFFF_F000_0020, power-on fetch PC loaded into all four thread PCs; bits [1:0] must be 0.
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- thr_en  in  4  per-thread fetch enable (bit N = thread N eligible).
- stall_f  in  1  F-stage hold; current fetch not accepted this cycle.
- redirect_vld  in  1  redirect strobe.
- redirect_thr  in  4  one-hot target thread of redirect; ignored when redirect_vld=0.
- redirect_pc  in  48  new PC; bits [1:0] ignored (forced 0).
- inst_vld_f  out  1  F-stage holds a valid fetch.
- thr_f  out  4  one-hot F-stage thread; 4'b0000 when inst_vld_f=0.
- pc_f  out  48  F-stage fetch PC (registered).
- t0pc_f, t1pc_f, t2pc_f, t3pc_f  out  48 each  per-thread next-fetch PC registers.

## Operation
- State: tpc[0..3] (48b, exported as tNpc_f); rr_last (2b, last granted thread); F regs thr_f, pc_f, inst_vld_f.
- Accept: acc = inst_vld_f & ~stall_f. Select opportunity: sel_ok = ~inst_vld_f | ~stall_f.
- Per-thread next PC, priority order: (1) redirect_vld & redirect_thr[N] -> {redirect_pc[47:2],2'b00}; (2) acc & thr_f[N] -> tpc[N]+4, mod 2^48 (48'hFFFF_FFFF_FFFC -> 0); (3) hold.
- Selection, only when sel_ok: search threads starting at (rr_last+1) mod 4 and wrapping. Grant the first with thr_en=1. Then thr_f <= onehot(grant), inst_vld_f <= 1, rr_last <= grant, pc_f <= next PC of grant. The next PC comes from the same-edge forwarded value above, not the old tpc.
- No enabled thread when sel_ok: inst_vld_f <= 0, thr_f <= 0, pc_f and rr_last hold.
- Stalled (inst_vld_f & stall_f): thr_f, inst_vld_f, rr_last hold. If a redirect hits the held thread, pc_f <= redirect PC together with tpc, so the invariant holds. Otherwise pc_f holds.
- thr_en deassert for the thread held in F while stalled: fetch stays valid until accepted. The thread is excluded only from later selections.
- redirect_thr with more than one bit set: every flagged thread is written. Single-thread use is the supported mode.
- Reset: tpc[0..3]=RESET_PC, pc_f=RESET_PC, thr_f=0, inst_vld_f=0, rr_last=3, so thread 0 has first priority. Reset overrides redirect/stall in the same cycle. Reset mid-fetch discards the fetch.

## Timing
- Selection to F-stage outputs: 1 cycle (registered). First valid fetch is the cycle after reset deasserts, if thr_en≠0.
- Redirect visibility: tpc updates the edge after redirect_vld. pc_f shows the redirect PC on the next grant of that thread, or immediately if that thread is stalled in F or granted on that edge.
- Redirect and accept of the same thread on one edge: redirect wins, with no +4.
- All four threads enabled, no stall: grant order 0,1,2,3,0…; each thread's PC advances by 4 every 4 cycles.
- Single enabled thread, no stall: inst_vld_f stays high every cycle and pc_f steps by 4 per cycle.
- Combinational input-to-output paths: none.

## Test plan
- Reset release, thr_en=4'hF, no stall -> thr_f 1,2,4,8,1. pc_f = 48'hFFFF_F000_0020 for the first four grants, then 48'hFFFF_F000_0024 on the 5th; t0pc_f = …0024 from cycle 2 on.
- thr_en=4'b0100, stall_f high for 3 cycles mid-stream -> thr_f=4'b0100 and pc_f frozen during the stall. pc_f increments by 4 per cycle after the stall ends, with no skipped PC.
- Redirect thread 1 to 48'h0000_0000_1003 while thread 1 is in F and accepted -> t1pc_f = 48'h0000_0000_1000 (not +4). The next thread-1 grant has pc_f = …1000.
- Redirect to a thread held under stall -> pc_f and tNpc_f both equal the redirect PC on the next cycle; inst_vld_f stays 1.
- PC wrap: redirect thread 3 to 48'hFFFF_FFFF_FFFC with only thread 3 enabled -> pc_f sequence FFFF_FFFF_FFFC, 0000_0000_0000, 0000_0000_0004.
- thr_en=0 -> inst_vld_f=0, thr_f=0. Enable thread 2 -> valid grant of thread 2 one cycle later. Assert reset mid-stream -> all outputs return to their reset values on the next edge.
